// File: rtl/datapath_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_pkg
// Shared definitions for the datapath sequencer. It holds:
//   - the data width of the operand/ALU datapath
//   - the opcode constants (HALT, PC-relative) and the ALUOp encoding for add
//   - the instruction field positions
//   - the sequencer state enum
//   - a sign-extension helper for the 4-bit immediate field
// -----------------------------------------------------------------------------
package datapath_sequencer_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] OP_PCREL  = 4'hE;
    localparam logic [2:0] ALUOP_ADD = 3'b000;

    // Instruction layout: [15:12] opcode, [11:8] rd, [7:4] rs0, [3:0] rs1/imm4
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS0_MSB = 7;
    localparam int RS0_LSB = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_CAPTURE,
        ST_WRITE,
        ST_HALT
    } state_e;

    function automatic logic signed [DATA_W-1:0] sext_imm4(input logic [3:0] imm4);
        return $signed({{(DATA_W-4){imm4[3]}}, imm4});
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Bundle of every signal between the sequencer and its environment
// (instruction memory, register file and ALU datapath).
//   master : the sequencer (drives fetch request, decode controls, write-back)
//   slave  : the environment (drives instr/instrValid and ALUOut)
// Signals:
//   instrReq/instrAddr/instr/instrValid : instruction fetch handshake
//   ALUOut                              : datapath ALU result
//   ALUOp/ALUSrcA/ALUSrcB/immediate     : ALU controls
//   rs0Addr/rs1Addr/rdAddr              : register-file addresses
//   writeEnable/dataWrite               : register-file write port
//   PC/halted                           : sequencer status
// -----------------------------------------------------------------------------
interface datapath_sequencer_if;
    import datapath_sequencer_pkg::*;

    logic                      instrReq;
    logic [INSTR_W-1:0]        instrAddr;
    logic [INSTR_W-1:0]        instr;
    logic                      instrValid;
    logic signed [DATA_W-1:0]  ALUOut;
    logic [2:0]                ALUOp;
    logic                      ALUSrcA;
    logic                      ALUSrcB;
    logic signed [DATA_W-1:0]  immediate;
    logic [3:0]                rs0Addr;
    logic [3:0]                rs1Addr;
    logic [3:0]                rdAddr;
    logic                      writeEnable;
    logic signed [DATA_W-1:0]  dataWrite;
    logic [INSTR_W-1:0]        PC;
    logic                      halted;

    modport master (
        output instrReq, instrAddr, ALUOp, ALUSrcA, ALUSrcB, immediate,
               rs0Addr, rs1Addr, rdAddr, writeEnable, dataWrite, PC, halted,
        input  instr, instrValid, ALUOut
    );

    modport slave (
        input  instrReq, instrAddr, ALUOp, ALUSrcA, ALUSrcB, immediate,
               rs0Addr, rs1Addr, rdAddr, writeEnable, dataWrite, PC, halted,
        output instr, instrValid, ALUOut
    );

endinterface

// File: rtl/datapath_sequencer_instr_decode.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_instr_decode
// Combinational decode of the latched instruction into ALU controls.
// Ports:
//   opcode_i  : IR[15:12]
//   imm4_i    : IR[3:0]
//   aluop_o   : ALU operation
//   alusrca_o : 0 = PC, 1 = register A
//   alusrcb_o : 0 = register B, 1 = immediate
//   imm_o     : sign-extended imm4
//   is_halt_o : opcode equals HALT_OP
// -----------------------------------------------------------------------------
module datapath_sequencer_instr_decode
    import datapath_sequencer_pkg::*;
#(
    parameter logic [3:0] HALT_OP = OP_HALT
) (
    input  logic [3:0]               opcode_i,
    input  logic [3:0]               imm4_i,
    output logic [2:0]               aluop_o,
    output logic                     alusrca_o,
    output logic                     alusrcb_o,
    output logic signed [DATA_W-1:0] imm_o,
    output logic                     is_halt_o
);

    // R-type is the default. HALT is tested first so a non-default HALT_OP
    // overrides whatever class its opcode would otherwise fall into.
    always_comb begin
        aluop_o   = opcode_i[2:0];
        alusrca_o = 1'b1;
        alusrcb_o = 1'b0;
        is_halt_o = 1'b0;
        if (opcode_i == HALT_OP) begin
            is_halt_o = 1'b1;
        end else if (opcode_i == OP_PCREL) begin
            aluop_o   = ALUOP_ADD;
            alusrca_o = 1'b0;
            alusrcb_o = 1'b1;
        end else if (opcode_i[3]) begin
            alusrcb_o = 1'b1;
        end
    end

    assign imm_o = sext_imm4(imm4_i);

endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Multi-cycle control sequencer for the 16-bit operand/ALU datapath.
// Each instruction runs FETCH -> DECODE -> EXEC -> CAPTURE -> WRITE; HALT is
// terminal until reset. Owns the PC, the instruction register and the
// write-back result register.
// Ports:
//   CLK   : clock, rising-edge
//   reset : synchronous, active-high
//   bus   : master side of datapath_sequencer_if (fetch handshake, ALU
//           controls, register addresses, write port, PC and halted status)
// -----------------------------------------------------------------------------
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = OP_HALT
) (
    input  logic                 CLK,
    input  logic                 reset,
    datapath_sequencer_if.master bus
);

    state_e                   state_q, state_d;
    logic [INSTR_W-1:0]       pc_q, pc_d;
    logic [INSTR_W-1:0]       ir_q, ir_d;
    logic signed [DATA_W-1:0] result_q, result_d;

    logic                     instr_req;
    logic                     write_en;
    logic [2:0]               aluop;
    logic                     alusrca;
    logic                     alusrcb;
    logic signed [DATA_W-1:0] imm;
    logic                     is_halt;

    datapath_sequencer_instr_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .opcode_i  (ir_q[OPC_MSB:OPC_LSB]),
        .imm4_i    (ir_q[RS1_MSB:RS1_LSB]),
        .aluop_o   (aluop),
        .alusrca_o (alusrca),
        .alusrcb_o (alusrcb),
        .imm_o     (imm),
        .is_halt_o (is_halt)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        result_d  = result_q;
        instr_req = 1'b0;
        write_en  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req = 1'b1;
                if (bus.instrValid) begin
                    ir_d    = bus.instr;
                    state_d = ST_DECODE;
                end
            end
            // The datapath latches A/B from rs0/rs1 at the end of this cycle.
            ST_DECODE: begin
                state_d = is_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                result_d = bus.ALUOut;
                state_d  = ST_WRITE;
            end
            // Strobe is masked by reset so a reset landing on WRITE never
            // commits a half-finished instruction.
            ST_WRITE: begin
                write_en = ~reset;
                pc_d     = pc_q + 16'd1;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign bus.instrReq    = instr_req;
    assign bus.instrAddr   = pc_q;
    assign bus.PC          = pc_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.writeEnable = write_en;
    assign bus.dataWrite   = result_q;
    assign bus.rdAddr      = ir_q[RD_MSB:RD_LSB];
    assign bus.rs0Addr     = ir_q[RS0_MSB:RS0_LSB];
    assign bus.rs1Addr     = ir_q[RS1_MSB:RS1_LSB];
    assign bus.ALUOp       = aluop;
    assign bus.ALUSrcA     = alusrca;
    assign bus.ALUSrcB     = alusrcb;
    assign bus.immediate   = imm;

endmodule
